ide_dma_controller: RTL and testbench
=====================================

IDE_DMA_CONTROLLER -- requirements
Module: ide_dma_controller

Interface
REQ-001 Parameter: BURST_WORDS, default 16, maximum words per DMARQ assertion (1..256).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse that begins a transfer.
REQ-005 dir  input  1  sampled at start: 1 = host writes (diow_ strobes, buffer written); 0 = host reads (dior_ strobes, buffer read).
REQ-006 word_last  input  8  index of the final word; transfer length = word_last+1 words (1..256).
REQ-007 abort  input  1  software or host reset request; cancels any transfer.
REQ-008 dmack_in  input  1  synchronized dmack_, active-low.
REQ-009 dior_in  input  1  synchronized dior_, active-low.
REQ-010 diow_in  input  1  synchronized diow_, active-low.
REQ-011 dmarq_asserted  output  1  drives the DMARQ pin enable.
REQ-012 dd_drive  output  1  data-bus output enable for DMA reads.
REQ-013 buf_addr  output  8  word address into the 256x16 data buffer (current word position).
REQ-014 buf_we  output  1  one-cycle buffer write strobe (dir=1 only).
REQ-015 busy  output  1  high from the cycle after start until the transfer ends.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 The block SHALL register dior_in, diow_in and dmack_in once (prev copies); strobe fall = prev high and current low; strobe rise = prev low and current high.
REQ-018 Active strobe SHALL be diow_in when dir=1 and dior_in when dir=0; the other strobe SHALL be ignored.
REQ-019 Strobe edges SHALL count only while dmack_in is low and state is XFER.
REQ-020 States: IDLE, REQ, XFER, PAUSE, DONE.
REQ-021 IDLE: start SHALL latch dir and word_last, clear pos and burst count, and enter REQ the next cycle; start in any other state SHALL be ignored.
REQ-022 REQ: dmarq_asserted SHALL be high; dmack_in low SHALL move the FSM to XFER.
REQ-023 XFER: dmarq_asserted SHALL stay high until the strobe fall that begins the last word of a burst (burst count = BURST_WORDS-1) or of the transfer (pos = word_last); it SHALL go low the cycle after that fall.
REQ-024 Each active strobe rise in XFER SHALL complete one word.
REQ-025 A completed word with pos = word_last SHALL move the FSM to DONE.
REQ-026 Otherwise, a completed word with burst count = BURST_WORDS-1 SHALL clear the burst count and move the FSM to PAUSE.
REQ-027 Otherwise pos and burst count SHALL each increment by 1.
REQ-028 On transfer completion (REQ-025) pos SHALL NOT increment.
REQ-029 On a burst boundary (REQ-026) pos SHALL increment by 1.
REQ-030 PAUSE: dmarq_asserted SHALL be low; dmack_in high SHALL return the FSM to REQ the next cycle.
REQ-031 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL enter IDLE with busy low.
REQ-032 buf_addr SHALL equal pos at all times.
REQ-033 When dir=1, buf_we SHALL pulse for one cycle on the cycle the diow_in rise is detected, with buf_addr still equal to the completing word.
REQ-034 dd_drive SHALL be 1 only when dir=0, state is XFER, dmack_in is low and dior_in is low.
REQ-035 pos is 8-bit; word_last=255 SHALL transfer 256 words with no wrap before completion.
REQ-036 A strobe fall and rise within the same sampled pair SHALL count once.
REQ-037 abort SHALL force IDLE on the next cycle, with dmarq_asserted, dd_drive, buf_we and busy low and no done pulse; abort overrides a simultaneous start.

Reset
REQ-038 On rst: state IDLE; pos, burst count, latched dir and word_last zero; prev strobe and dmack copies 1; all outputs 0.
REQ-039 rst SHALL have priority over abort and start.

Verification
REQ-040 dir=1, word_last=3, BURST_WORDS=16, dmack low, 4 diow pulses -> buf_we at addr 0,1,2,3; dmarq low after 4th fall; done 1 cycle; busy low.
REQ-041 dir=0, word_last=19, BURST_WORDS=16 -> dmarq drops after 16th fall, PAUSE until dmack high, re-asserts; 4 more words; done; dd_drive only during dior low.
REQ-042 dir=1 with dior pulses only, or diow pulses while dmack high -> no buf_we, pos stays 0, dmarq stays high.
REQ-043 word_last=255, BURST_WORDS=256 -> 256 words, addresses 0..255, single burst, done once.
REQ-044 abort after 5 words -> IDLE next cycle, dmarq low, no done; new start then restarts at addr 0.
REQ-045 rst asserted in XFER -> all outputs 0 next cycle; start 1 cycle after rst release is accepted.

Source files
------------

// File: rtl/ide_dma_controller.sv
// IDE/ATA multiword DMA sequencer: raises DMARQ, counts host strobe handshakes
// per word, splits long transfers into bursts and drives the buffer address/write strobe.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | DMARQ high, waiting for DMACK
// XFER  | counting host strobes, one word per rise
// PAUSE | burst finished, waiting for DMACK release
// DONE  | one-cycle completion pulse
module ide_dma_controller #(
    parameter int BURST_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic [7:0] word_last,
    input  logic       abort,
    input  logic       dmack_in,
    input  logic       dior_in,
    input  logic       diow_in,
    output logic       dmarq_asserted,
    output logic       dd_drive,
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] BURST_LAST = 8'(BURST_WORDS - 1);

    typedef enum logic [2:0] {IDLE, REQ, XFER, PAUSE, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] pos, burst_cnt, last_q;
    logic       dir_q, prev_dior, prev_diow, stop_q;
    logic       act_prev, act_cur, counting, strobe_fall, strobe_rise;
    logic       at_last, at_burst_end;

    assign act_prev     = dir_q ? prev_diow : prev_dior;
    assign act_cur      = dir_q ? diow_in : dior_in;
    assign counting     = (state == XFER) && !dmack_in;
    assign strobe_fall  = counting && act_prev && !act_cur;
    assign strobe_rise  = counting && !act_prev && act_cur;
    assign at_last      = (pos == last_q);
    assign at_burst_end = (burst_cnt == BURST_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (!dmack_in) state_nx = XFER;
            XFER: begin
                if (strobe_rise) begin
                    if (at_last)           state_nx = DONE;
                    else if (at_burst_end) state_nx = PAUSE;
                end
            end
            PAUSE:   if (dmack_in) state_nx = REQ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            burst_cnt <= '0;
            last_q    <= '0;
            dir_q     <= 1'b0;
            stop_q    <= 1'b0;
            prev_dior <= 1'b1;
            prev_diow <= 1'b1;
        end else begin
            state     <= state_nx;
            prev_dior <= dior_in;
            prev_diow <= diow_in;
            if (abort) begin
                stop_q <= 1'b0;
            end else if (state == IDLE && start) begin
                dir_q     <= dir;
                last_q    <= word_last;
                pos       <= '0;
                burst_cnt <= '0;
                stop_q    <= 1'b0;
            end else if (strobe_rise) begin
                stop_q <= 1'b0;
                // the final word leaves pos on itself so buf_addr still names it
                if (!at_last) begin
                    pos <= pos + 8'd1;
                    if (at_burst_end) burst_cnt <= '0;
                    else              burst_cnt <= burst_cnt + 8'd1;
                end
            end else if (strobe_fall && (at_last || at_burst_end)) begin
                stop_q <= 1'b1;
            end
        end
    end

    assign dmarq_asserted = (state == REQ) || ((state == XFER) && !stop_q);
    assign dd_drive       = !dir_q && (state == XFER) && !dmack_in && !dior_in;
    assign buf_addr       = pos;
    assign buf_we         = dir_q && strobe_rise;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

endmodule

// File: tb/tb_ide_dma_controller.sv
// Directed bench for ide_dma_controller: a cycle table for the short write and
// ignored-strobe cases, plus hand sequences for bursts, long transfer, abort and reset.
module tb_ide_dma_controller;

    logic       clk = 1'b0;
    logic       rst, start, dir, abort, dmack, dior, diow;
    logic [7:0] word_last;
    logic       dmarq, dd, we, busy, done;
    logic [7:0] addr;
    logic       b_dmarq, b_dd, b_we, b_busy, b_done;
    logic [7:0] b_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ide_dma_controller #(.BURST_WORDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .word_last(word_last),
        .abort(abort), .dmack_in(dmack), .dior_in(dior), .diow_in(diow),
        .dmarq_asserted(dmarq), .dd_drive(dd), .buf_addr(addr), .buf_we(we),
        .busy(busy), .done(done)
    );

    ide_dma_controller #(.BURST_WORDS(256)) dut_big (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .word_last(word_last),
        .abort(abort), .dmack_in(dmack), .dior_in(dior), .diow_in(diow),
        .dmarq_asserted(b_dmarq), .dd_drive(b_dd), .buf_addr(b_addr), .buf_we(b_we),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic       start, dir;
        logic [7:0] wl;
        logic       abort, dmack, dior, diow;
        logic       e_dmarq, e_dd;
        logic [7:0] e_addr;
        logic       e_we, e_busy, e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, d, input logic [7:0] w, input logic a, k, r, x,
                                input logic q, o, input logic [7:0] ad, input logic e, b, n);
        vec_t v;
        v.start = s; v.dir = d; v.wl = w; v.abort = a; v.dmack = k; v.dior = r; v.diow = x;
        v.e_dmarq = q; v.e_dd = o; v.e_addr = ad; v.e_we = e; v.e_busy = b; v.e_done = n;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic begin_xfer(input logic d, input logic [7:0] w, input string tag);
        cyc(); start = 1'b1; dir = d; word_last = w; dmack = 1'b1; dior = 1'b1; diow = 1'b1;
        settle(); chk({tag, "_idle_busy"}, busy, 0);
        cyc(); start = 1'b0; dmack = 1'b0;
        settle();
        chk({tag, "_req_dmarq"}, dmarq, 1);
        chk({tag, "_req_busy"}, busy, 1);
        chk({tag, "_req_addr"}, addr, 0);
    endtask

    task automatic word(input int idx, input logic wr, input logic exp_dmarq, input string tag);
        cyc(); if (wr) diow = 1'b0; else dior = 1'b0;
        settle();
        chk({tag, "_fall_addr"}, addr, idx);
        chk({tag, "_fall_dd"}, dd, !wr);
        chk({tag, "_fall_we"}, we, 0);
        chk({tag, "_fall_dmarq"}, dmarq, 1);
        cyc(); diow = 1'b1; dior = 1'b1;
        settle();
        chk({tag, "_rise_addr"}, addr, idx);
        chk({tag, "_rise_we"}, we, wr);
        chk({tag, "_rise_dd"}, dd, 0);
        chk({tag, "_rise_dmarq"}, dmarq, exp_dmarq);
    endtask

    task automatic finish_chk(input string tag);
        cyc(); dmack = 1'b1;
        settle();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        cyc();
        settle();
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_after_busy"}, busy, 0);
        chk({tag, "_after_dmarq"}, dmarq, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; word_last = 8'd0; abort = 1'b0;
        dmack = 1'b1; dior = 1'b1; diow = 1'b1;
        repeat (2) cyc();
        settle();
        chk("rst_dmarq", dmarq, 0); chk("rst_dd", dd, 0); chk("rst_addr", addr, 0);
        chk("rst_we", we, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        cyc(); rst = 1'b0;

        // write of 4 words: st dir wl ab dk rd wr | dmarq dd addr we busy done
        add(1,1,8'd3,0,1,1,1, 0,0,8'd0,0,0,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,0,1,0, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd0,1,1,0);
        add(0,1,8'd3,0,0,1,0, 1,0,8'd1,0,1,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd1,1,1,0);
        add(0,1,8'd3,0,0,1,0, 1,0,8'd2,0,1,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd2,1,1,0);
        add(0,1,8'd3,0,0,1,0, 1,0,8'd3,0,1,0);
        add(0,1,8'd3,0,0,1,0, 0,0,8'd3,0,1,0);
        add(0,1,8'd3,0,0,1,1, 0,0,8'd3,1,1,0);
        add(0,1,8'd3,0,1,1,1, 0,0,8'd3,0,1,1);
        add(0,1,8'd3,0,1,1,1, 0,0,8'd3,0,0,0);
        // write transfer fed only wrong/unacknowledged strobes, then aborted
        add(1,1,8'd3,0,1,1,1, 0,0,8'd3,0,0,0);
        add(0,1,8'd3,0,1,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,1,1,0, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,1,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,0,0,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,0,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,1,1,0, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,1,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,1,1,1,1, 1,0,8'd0,0,1,0);
        add(0,1,8'd3,0,1,1,1, 0,0,8'd0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc();
            start = vecs[i].start; dir = vecs[i].dir; word_last = vecs[i].wl;
            abort = vecs[i].abort; dmack = vecs[i].dmack; dior = vecs[i].dior; diow = vecs[i].diow;
            settle();
            chk($sformatf("vec%0d_dmarq", i), dmarq, vecs[i].e_dmarq);
            chk($sformatf("vec%0d_dd", i), dd, vecs[i].e_dd);
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_we", i), we, vecs[i].e_we);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
        end

        // 20-word read: burst of 16, pause, burst of 4
        begin_xfer(1'b0, 8'd19, "rd20");
        for (int i = 0; i < 16; i++) word(i, 1'b0, (i != 15), $sformatf("rd20_w%0d", i));
        cyc(); settle();
        chk("rd20_pause_dmarq", dmarq, 0); chk("rd20_pause_busy", busy, 1);
        chk("rd20_pause_addr", addr, 16);
        cyc(); dmack = 1'b1; settle();
        chk("rd20_pause_ack_hi", dmarq, 0);
        cyc(); dmack = 1'b0; settle();
        chk("rd20_rereq_dmarq", dmarq, 1);
        for (int i = 16; i < 20; i++) word(i, 1'b0, (i != 19), $sformatf("rd20_w%0d", i));
        finish_chk("rd20");

        // 256-word write on the single-burst instance
        cyc(); abort = 1'b1;
        cyc(); abort = 1'b0; start = 1'b1; dir = 1'b1; word_last = 8'd255; dmack = 1'b1;
        cyc(); start = 1'b0; dmack = 1'b0; settle();
        chk("big_req_dmarq", b_dmarq, 1);
        for (int i = 0; i < 256; i++) begin
            cyc(); diow = 1'b0; settle();
            chk($sformatf("big_w%0d_fall_addr", i), b_addr, i);
            chk($sformatf("big_w%0d_fall_dmarq", i), b_dmarq, 1);
            cyc(); diow = 1'b1; settle();
            chk($sformatf("big_w%0d_we", i), b_we, 1);
            chk($sformatf("big_w%0d_rise_addr", i), b_addr, i);
            chk($sformatf("big_w%0d_rise_dmarq", i), b_dmarq, (i != 255));
        end
        cyc(); dmack = 1'b1; settle();
        chk("big_done", b_done, 1); chk("big_done_addr", b_addr, 255);
        cyc(); settle();
        chk("big_after_done", b_done, 0); chk("big_after_busy", b_busy, 0);
        cyc(); abort = 1'b1;
        cyc(); abort = 1'b0;

        // abort after 5 words, then restart from address 0
        begin_xfer(1'b1, 8'd9, "ab");
        for (int i = 0; i < 5; i++) word(i, 1'b1, 1'b1, $sformatf("ab_w%0d", i));
        cyc(); abort = 1'b1; settle();
        chk("ab_abort_cycle_busy", busy, 1);
        cyc(); abort = 1'b0; settle();
        chk("ab_idle_dmarq", dmarq, 0); chk("ab_idle_busy", busy, 0);
        chk("ab_idle_done", done, 0); chk("ab_idle_we", we, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            chk($sformatf("ab_nodone%0d", i), done, 0);
        end
        begin_xfer(1'b1, 8'd1, "ab_re");
        word(0, 1'b1, 1'b1, "ab_re_w0");
        word(1, 1'b1, 1'b0, "ab_re_w1");
        finish_chk("ab_re");

        // synchronous reset in the middle of a read
        begin_xfer(1'b0, 8'd9, "rs");
        word(0, 1'b0, 1'b1, "rs_w0");
        word(1, 1'b0, 1'b1, "rs_w1");
        cyc(); dior = 1'b0; settle();
        chk("rs_pre_dd", dd, 1);
        cyc(); rst = 1'b1; start = 1'b1; abort = 1'b1;
        cyc(); rst = 1'b0; start = 1'b0; abort = 1'b0; settle();
        chk("rs_dmarq", dmarq, 0); chk("rs_dd", dd, 0); chk("rs_addr", addr, 0);
        chk("rs_we", we, 0); chk("rs_busy", busy, 0); chk("rs_done", done, 0);
        dior = 1'b1; dmack = 1'b1;
        begin_xfer(1'b1, 8'd0, "rs_re");
        word(0, 1'b1, 1'b0, "rs_re_w0");
        finish_chk("rs_re");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
